// File: rtl/circular_dma_arbiter.sv
// Packet-level round-robin arbiter merging C_NUM_INPUTS AXI-Stream sources
// into the single S2MM stream of the circular DMA; grants last a whole packet.
//
// state | meaning
// IDLE  | no grant held; picks the next requester after last_grant when enabled
// BUSY  | granted input passed through until its tlast beat is accepted
module circular_dma_arbiter #(
  parameter int C_NUM_INPUTS = 4,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_ID_WIDTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  output logic                                 busy,
  output logic [31:0]                          pkt_count,
  input  logic [C_NUM_INPUTS*C_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_INPUTS-1:0]              s_axis_tlast,
  input  logic [C_NUM_INPUTS-1:0]              s_axis_tvalid,
  output logic [C_NUM_INPUTS-1:0]              s_axis_tready,
  output logic [C_AXIS_WIDTH-1:0]              m_axis_tdata,
  output logic                                 m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]                m_axis_tid,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [C_ID_WIDTH-1:0]   grant, grant_d;
  logic [C_ID_WIDTH-1:0]   last_grant, last_grant_d;
  logic [31:0]             pkt_count_d;

  logic [C_AXIS_WIDTH-1:0] sel_data;
  logic                    sel_last;
  logic                    sel_valid;
  logic                    arb_found;
  logic [C_ID_WIDTH-1:0]   arb_idx;
  int                      arb_dist;
  int                      best_dist;

  // Source mux follows grant in both states so the idle outputs are never X.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < C_NUM_INPUTS; i++) begin
      if (int'(grant) == i) begin
        sel_data  = s_axis_tdata[i*C_AXIS_WIDTH +: C_AXIS_WIDTH];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  // Round-robin pick: requester with the smallest distance past last_grant,
  // measured modulo C_NUM_INPUTS so unused id codes are never produced.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_dist  = 0;
    best_dist = C_NUM_INPUTS;
    for (int i = 0; i < C_NUM_INPUTS; i++) begin
      arb_dist = (i + C_NUM_INPUTS - 1 - int'(last_grant)) % C_NUM_INPUTS;
      if (s_axis_tvalid[i] && (arb_dist < best_dist)) begin
        arb_found = 1'b1;
        arb_idx   = C_ID_WIDTH'(i);
        best_dist = arb_dist;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant;
    last_grant_d  = last_grant;
    pkt_count_d   = pkt_count;
    busy          = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      IDLE: begin
        if (enable && arb_found) begin
          grant_d = arb_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy          = 1'b1;
        m_axis_tvalid = sel_valid;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
          s_axis_tready[i] = (int'(grant) == i) && m_axis_tready;
        end
        if (sel_valid && m_axis_tready && sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant;
          pkt_count_d  = pkt_count + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant      <= '0;
      last_grant <= C_ID_WIDTH'(C_NUM_INPUTS - 1);
      pkt_count  <= '0;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      pkt_count  <= pkt_count_d;
    end
  end

  assign m_axis_tdata = sel_data;
  assign m_axis_tlast = sel_last;
  assign m_axis_tid   = grant;

endmodule

// File: tb/tb_circular_dma_arbiter.sv
// Bench for circular_dma_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a packet-level round-robin reference model.
module tb_circular_dma_arbiter;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           busy;
  logic [31:0]    pkt_count;
  logic [N*W-1:0] s_axis_tdata;
  logic [N-1:0]   s_axis_tlast;
  logic [N-1:0]   s_axis_tvalid;
  logic [N-1:0]   s_axis_tready;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tlast;
  logic [IDW-1:0] m_axis_tid;
  logic           m_axis_tvalid;
  logic           m_axis_tready;

  circular_dma_arbiter #(.C_NUM_INPUTS(N), .C_AXIS_WIDTH(W), .C_ID_WIDTH(IDW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .busy(busy), .pkt_count(pkt_count),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  typedef struct {
    int           cyc;
    int           tid;
    logic         last;
    logic [W-1:0] data;
  } obs_t;

  beat_t        src_q [N][$];
  obs_t         out_q [$];
  logic [N-1:0] src_hold;
  logic [N-1:0] acc;
  logic [N-1:0] smp_tready;
  int           smp_tid;
  logic         smp_busy;
  logic         smp_mvalid;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !src_hold[i]) begin
        s_axis_tvalid[i]          = 1'b1;
        s_axis_tlast[i]           = src_q[i][0].last;
        s_axis_tdata[i*W +: W]    = src_q[i][0].data;
      end else begin
        s_axis_tvalid[i]          = 1'b0;
        s_axis_tlast[i]           = 1'b0;
        s_axis_tdata[i*W +: W]    = '0;
      end
    end
  endtask

  task automatic push_pkt(input int src, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) begin
      src_q[src].push_back('{last: (b == len - 1), data: base + W'(b)});
    end
    drive_inputs();
  endtask

  task automatic sample();
    @(negedge clk);
    acc        = s_axis_tvalid & s_axis_tready;
    smp_tready = s_axis_tready;
    smp_tid    = int'(m_axis_tid);
    smp_busy   = busy;
    smp_mvalid = m_axis_tvalid;
    if (m_axis_tvalid && m_axis_tready)
      out_q.push_back('{cyc: cyc, tid: int'(m_axis_tid), last: m_axis_tlast, data: m_axis_tdata});
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive_inputs();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    src_hold = '0;
    drive_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    out_q.delete();
  endtask

  task automatic test_reset();
    enable = 1'b1;
    m_axis_tready = 1'b1;
    do_reset();
    n_checks++;
    if ({busy, m_axis_tvalid, s_axis_tready} !== 6'b0)
      $display("FAIL reset_idle: busy/tvalid/tready got %b want 000000", {busy, m_axis_tvalid, s_axis_tready});
    else n_pass++;
    n_checks++;
    if (pkt_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", pkt_count);
    else n_pass++;
    n_checks++;
    if (m_axis_tid !== 2'd0) $display("FAIL reset_tid: got %0d want 0", m_axis_tid);
    else n_pass++;
    n_checks++;
    if ($isunknown({m_axis_tdata, m_axis_tlast})) $display("FAIL reset_no_x: got %h want known", m_axis_tdata);
    else n_pass++;
    cycle();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_no_req: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_packet();
    int req_cyc;
    do_reset();
    push_pkt(2, 3, W'('hA0));
    req_cyc = cyc;
    for (int t = 0; t < 20 && out_q.size() < 3; t++) cycle();
    n_checks++;
    if (out_q.size() !== 3) $display("FAIL single_beats: got %0d want 3", out_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (out_q[0].cyc !== req_cyc + 1)
        $display("FAIL single_latency: got %0d want %0d", out_q[0].cyc - req_cyc, 1);
      else n_pass++;
      for (int b = 0; b < 3; b++) begin
        n_checks++;
        if (out_q[b].tid !== 2 || out_q[b].last !== (b == 2) || out_q[b].data !== W'('hA0 + b))
          $display("FAIL single_beat%0d: got tid=%0d last=%b data=%h want tid=2 last=%b data=%h",
                   b, out_q[b].tid, out_q[b].last, out_q[b].data, (b == 2), W'('hA0 + b));
        else n_pass++;
      end
    end
    n_checks++;
    if ({busy, pkt_count} !== {1'b0, 32'd1})
      $display("FAIL single_after: got busy=%b count=%0d want busy=0 count=1", busy, pkt_count);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 3; p++) push_pkt(i, 2, W'('h1000 * i + 'h10 * p));
    for (int t = 0; t < 100 && out_q.size() < 12; t++) cycle();
    n_checks++;
    if (out_q.size() !== 12) $display("FAIL rr_beats: got %0d want 12", out_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 6; k++) begin
        int tid_e;
        logic [W-1:0] d_e;
        tid_e = k % N;
        d_e = W'('h1000 * tid_e + 'h10 * (k / N));
        n_checks++;
        if (out_q[2*k].tid !== tid_e || out_q[2*k+1].tid !== tid_e ||
            out_q[2*k].data !== d_e || out_q[2*k+1].data !== d_e + 1 ||
            out_q[2*k].last !== 1'b0 || out_q[2*k+1].last !== 1'b1)
          $display("FAIL rr_pkt%0d: got tid=%0d data=%h want tid=%0d data=%h",
                   k, out_q[2*k].tid, out_q[2*k].data, tid_e, d_e);
        else n_pass++;
        if (k > 0) begin
          n_checks++;
          if (out_q[2*k].cyc - out_q[2*k-1].cyc !== 2 || out_q[2*k+1].cyc - out_q[2*k].cyc !== 1)
            $display("FAIL rr_spacing%0d: got gap=%0d want 2", k, out_q[2*k].cyc - out_q[2*k-1].cyc);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pkt_count !== 32'd6) $display("FAIL rr_count: got %0d want 6", pkt_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int viol = 0;
    int gap_left = 0;
    bit gapped = 0;
    do_reset();
    push_pkt(1, 6, W'('h10));
    cycle();
    push_pkt(0, 2, W'('h200));
    push_pkt(2, 2, W'('h220));
    push_pkt(3, 2, W'('h230));
    for (int t = 0; t < 60 && out_q.size() < 6; t++) begin
      m_axis_tready = (t % 2 == 0);
      if (out_q.size() == 2 && !gapped) begin
        gapped = 1;
        gap_left = 3;
        src_hold[1] = 1'b1;
        drive_inputs();
      end
      cycle();
      if (smp_tid !== 1 || smp_busy !== 1'b1 || (smp_tready & 4'b1101) !== 4'b0) viol++;
      if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) begin
          src_hold[1] = 1'b0;
          drive_inputs();
        end
      end
    end
    m_axis_tready = 1'b1;
    n_checks++;
    if (viol !== 0) $display("FAIL bp_grant_held: got %0d bad cycles want 0", viol);
    else n_pass++;
    n_checks++;
    if (out_q.size() !== 6) $display("FAIL bp_beats: got %0d want 6", out_q.size());
    else begin
      n_pass++;
      for (int b = 0; b < 6; b++) begin
        n_checks++;
        if (out_q[b].tid !== 1 || out_q[b].data !== W'('h10 + b) || out_q[b].last !== (b == 5))
          $display("FAIL bp_beat%0d: got tid=%0d data=%h want tid=1 data=%h", b, out_q[b].tid,
                   out_q[b].data, W'('h10 + b));
        else n_pass++;
      end
    end
  endtask

  task automatic test_enable_drain();
    int viol = 0;
    do_reset();
    enable = 1'b1;
    m_axis_tready = 1'b1;
    push_pkt(3, 4, W'('h30));
    for (int t = 0; t < 20 && out_q.size() < 4; t++) begin
      cycle();
      if (out_q.size() == 1 && enable) begin
        enable = 1'b0;
        push_pkt(0, 1, W'('h300));
        push_pkt(1, 1, W'('h310));
      end
    end
    n_checks++;
    if (out_q.size() !== 4 || out_q[3].data !== W'('h33) || out_q[3].tid !== 3 || out_q[3].last !== 1'b1)
      $display("FAIL drain_complete: got %0d beats want 4 ending at 33", out_q.size());
    else n_pass++;
    for (int t = 0; t < 8; t++) begin
      cycle();
      if (smp_busy !== 1'b0 || smp_mvalid !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0 || out_q.size() !== 4)
      $display("FAIL drain_no_grant: got %0d busy cycles want 0", viol);
    else n_pass++;
    enable = 1'b1;
    for (int t = 0; t < 10 && out_q.size() < 5; t++) cycle();
    n_checks++;
    if (out_q.size() !== 5) $display("FAIL reenable_beats: got %0d want 5", out_q.size());
    else if (out_q[4].tid !== 0 || out_q[4].data !== W'('h300))
      $display("FAIL reenable_grant: got tid=%0d data=%h want tid=0 data=300", out_q[4].tid, out_q[4].data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    m_axis_tready = 1'b1;
    push_pkt(1, 5, W'('h50));
    cycle();
    push_pkt(2, 2, W'('h520));
    push_pkt(3, 2, W'('h530));
    for (int t = 0; t < 20 && out_q.size() < 2; t++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({m_axis_tvalid, busy, pkt_count} !== {2'b00, 32'd0})
      $display("FAIL midrst_squash: got tvalid=%b busy=%b count=%0d want 0 0 0", m_axis_tvalid, busy, pkt_count);
    else n_pass++;
    src_q[1].delete();
    push_pkt(1, 2, W'('h60));
    out_q.delete();
    for (int t = 0; t < 10 && out_q.size() < 1; t++) cycle();
    n_checks++;
    if (out_q.size() !== 1 || out_q[0].tid !== 1 || out_q[0].data !== W'('h60))
      $display("FAIL midrst_next_grant: got %0d beats want tid=1 data=60", out_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    m_axis_tready = 1'b1;
    for (int k = 0; k < 1000; k++) src_q[0].push_back('{last: 1'b1, data: W'(k)});
    drive_inputs();
    for (int t = 0; t < 2200 && out_q.size() < 1000; t++) cycle();
    n_checks++;
    if (out_q.size() !== 1000) $display("FAIL b2b_beats: got %0d want 1000", out_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 1000; k++) begin
        if (out_q[k].tid !== 0 || out_q[k].data !== W'(k) || out_q[k].last !== 1'b1) bad++;
        if (k > 0 && out_q[k].cyc - out_q[k-1].cyc !== 2) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL b2b_stream: got %0d bad beats want 0", bad);
      else n_pass++;
    end
    n_checks++;
    if (pkt_count !== 32'd1000) $display("FAIL b2b_count: got %0d want 1000", pkt_count);
    else n_pass++;
  endtask

  task automatic test_random();
    bit          mb = 0;
    int          mg = 0;
    int          ml = N - 1;
    int unsigned mcnt = 0;
    logic [N-1:0] exp_rdy;
    int bad_ctl = 0;
    int bad_dat = 0;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            src_q[i].push_back('{last: (b == len - 1), data: {$urandom, $urandom}});
        end
        src_hold[i] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      drive_inputs();
      sample();
      exp_rdy = '0;
      if (mb && m_axis_tready) exp_rdy[mg] = 1'b1;
      n_checks++;
      if ({busy, m_axis_tvalid, s_axis_tready} !== {mb, mb && s_axis_tvalid[mg], exp_rdy}) begin
        if (bad_ctl < 5)
          $display("FAIL rand_ctl cyc %0d: got busy/valid/ready=%b want %b", cyc,
                   {busy, m_axis_tvalid, s_axis_tready}, {mb, mb && s_axis_tvalid[mg], exp_rdy});
        bad_ctl++;
      end else n_pass++;
      if (mb && s_axis_tvalid[mg]) begin
        n_checks++;
        if (int'(m_axis_tid) !== mg || m_axis_tlast !== src_q[mg][0].last || m_axis_tdata !== src_q[mg][0].data) begin
          if (bad_dat < 5)
            $display("FAIL rand_data cyc %0d: got tid=%0d data=%h want tid=%0d data=%h", cyc,
                     m_axis_tid, m_axis_tdata, mg, src_q[mg][0].data);
          bad_dat++;
        end else n_pass++;
      end
      if (!mb) begin
        if (enable) begin
          for (int k = 1; k <= N; k++) begin
            if (!mb && s_axis_tvalid[(ml + k) % N]) begin
              mb = 1;
              mg = (ml + k) % N;
            end
          end
        end
      end else if (s_axis_tvalid[mg] && m_axis_tready && src_q[mg][0].last) begin
        mb = 0;
        ml = mg;
        mcnt++;
      end
      advance();
    end
    enable = 1'b1;
    n_checks++;
    if (pkt_count !== mcnt) $display("FAIL rand_count: got %0d want %0d", pkt_count, mcnt);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    m_axis_tready = 1'b1;
    src_hold = '0;
    acc = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_enable_drain();
    test_reset_mid_packet();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
